display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 14 +
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, types and the hex segment table for the display scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns, indexed by hex value
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [0:0] {
        ST_SCAN  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic       blank;
        logic [3:0] value;
    } digit_t;

    localparam digit_t DIGIT_RST = '{blank: 1'b1, value: 4'h0};

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to active-low seven-segment decoder.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup of the segment pattern
    always_comb begin
        seg_o = HEX_SEG[hex_i];
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with digit write port and clear sequencer.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SEL_W-1:0]      wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_blank,
    input  logic                  clr,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEG_W-1:0]      seg,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLANK_START = REFRESH_DIV - BLANK_CYCLES;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [SEL_W-1:0]        digit_sel_q, digit_sel_d;
    digit_t                  digits_q [NUM_DIGITS];
    digit_t                  digits_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    frame_tick_q, frame_tick_d;

    digit_t                  cur_digit;
    logic [SEG_W-1:0]        dec_seg;
    logic                    slot_last;
    logic                    in_blank;

    assign cur_digit = digits_q[digit_sel_q];
    assign slot_last = (slot_cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign in_blank  = (32'(slot_cnt_q) >= 32'(BLANK_START));

    seg7_decode u_seg7_decode (
        .hex_i (cur_digit.value),
        .seg_o (dec_seg)
    );

    // Writes are only taken while scanning and never alongside a clear request
    assign wr_ready   = (state_q == ST_SCAN) && !clr;
    assign busy       = (state_q == ST_CLEAR);
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

    // Next-state: scan counters, output pipeline, clear sequencer and digit writes
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        digits_d     = digits_q;
        slot_cnt_d   = slot_last ? '0 : slot_cnt_q + CNT_W'(1);
        digit_sel_d  = slot_last ? digit_sel_q + SEL_W'(1) : digit_sel_q;
        frame_tick_d = slot_last && (digit_sel_q == SEL_W'(NUM_DIGITS - 1));
        anode_d      = '1;
        seg_d        = SEG_BLANK;

        if (!cur_digit.blank && !in_blank) begin
            anode_d = ~(NUM_DIGITS'(1) << digit_sel_q);
            seg_d   = dec_seg;
        end

        case (state_q)
            ST_SCAN: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (wr_valid && wr_ready) begin
                    digits_d[wr_addr] = '{blank: wr_blank, value: wr_data};
                end
            end
            ST_CLEAR: begin
                // One digit per cycle; scanning carries on underneath
                digits_d[clr_cnt_q] = DIGIT_RST;
                clr_cnt_d           = clr_cnt_q + SEL_W'(1);
                if (clr_cnt_q == SEL_W'(NUM_DIGITS - 1)) begin
                    state_d = ST_SCAN;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SCAN;
            clr_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            digit_sel_q  <= '0;
            anode_q      <= '1;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= DIGIT_RST;
            end
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            digit_sel_q  <= digit_sel_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= digits_d[i];
            end
        end
    end

endmodule
